// File: rtl/corr_pkt_pkg.sv
// Shared frame layout and read-FSM encodings for the correlator frame packer.
package corr_pkt_pkg;

  localparam logic [2:0] W_HDR  = 3'd0;
  localparam logic [2:0] W_AA   = 3'd1;
  localparam logic [2:0] W_BB   = 3'd2;
  localparam logic [2:0] W_ABRE = 3'd3;
  localparam logic [2:0] W_ABIM = 3'd4;

  localparam int unsigned N_FIELDS = 5;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SEND = 1'b1;

  function automatic int unsigned frame_words(input bit include_header);
    return include_header ? 5 : 4;
  endfunction

endpackage

// File: rtl/corr_frame_fifo.sv
// Frame FIFO: one row per frame, registered level/flags, push+pop allowed when full.
module corr_frame_fifo #(
  parameter int unsigned ROW_W = 160,
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic [ROW_W-1:0]           i_wr_row,
  output logic [ROW_W-1:0]           o_head_row,
  output logic [ROW_W-1:0]           o_next_row,
  output logic [$clog2(DEPTH):0]     o_level,
  output logic                       o_full,
  output logic                       o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [ROW_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_level;
  logic             r_full;
  logic             r_empty;
  logic [LW-1:0]    w_level_nxt;

  always_comb begin
    w_level_nxt = r_level;
    case ({i_push, i_pop})
      2'b10:   w_level_nxt = r_level + LW'(1);
      2'b01:   w_level_nxt = r_level - LW'(1);
      default: w_level_nxt = r_level;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_level <= w_level_nxt;
      r_full  <= (w_level_nxt == LW'(DEPTH));
      r_empty <= (w_level_nxt == '0);
    end
  end

  // Storage is not reset; pointers alone define valid contents.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_wr_row;
  end

  assign o_head_row = r_mem[r_rd_ptr];
  assign o_next_row = r_mem[r_rd_ptr + AW'(1)];
  assign o_level    = r_level;
  assign o_full     = r_full;
  assign o_empty    = r_empty;

endmodule

// File: rtl/corr_frame_packer.sv
// Buffers correlator accumulations as frames and drains them as a word-serial AXI-Stream.
module corr_frame_packer
  import corr_pkt_pkg::*;
#(
  parameter int unsigned DIN_WIDTH      = 32,
  parameter int unsigned FIFO_DEPTH     = 8,
  parameter int unsigned INCLUDE_HEADER = 1,
  parameter int unsigned DROP_CNT_WIDTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DIN_WIDTH-1:0]          aa,
  input  logic [DIN_WIDTH-1:0]          bb,
  input  logic [DIN_WIDTH-1:0]          ab_re,
  input  logic [DIN_WIDTH-1:0]          ab_im,
  input  logic                          din_valid,
  output logic [DIN_WIDTH-1:0]          m_axis_tdata,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tlast,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [DROP_CNT_WIDTH-1:0]     drop_count,
  output logic                          overflow,
  input  logic                          clear_stats
);

  localparam int unsigned ROW_W = N_FIELDS * DIN_WIDTH;
  localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [2:0]  FIRST_IDX = 3'(N_FIELDS - frame_words(INCLUDE_HEADER != 0));

  logic [DIN_WIDTH-1:0]      r_seq;
  logic [DROP_CNT_WIDTH-1:0] r_drop_cnt;
  logic                      r_overflow;
  logic [0:0]                r_state;
  logic [2:0]                r_idx;
  logic [DIN_WIDTH-1:0]      r_tdata;
  logic                      r_tvalid;
  logic                      r_tlast;

  logic [0:0]           w_state_nxt;
  logic [2:0]           w_idx_nxt;
  logic [2:0]           w_idx_inc;
  logic [DIN_WIDTH-1:0] w_tdata_nxt;
  logic                 w_tvalid_nxt;
  logic                 w_tlast_nxt;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_drop;
  logic                 w_full;
  logic                 w_empty;
  logic [LVL_W-1:0]     w_level;
  logic [ROW_W-1:0]     w_wr_row;
  logic [ROW_W-1:0]     w_head_row;
  logic [ROW_W-1:0]     w_next_row;

  function automatic logic [DIN_WIDTH-1:0] sel_word(input logic [ROW_W-1:0] row,
                                                    input logic [2:0] idx);
    case (idx)
      W_HDR:   return row[4*DIN_WIDTH +: DIN_WIDTH];
      W_AA:    return row[3*DIN_WIDTH +: DIN_WIDTH];
      W_BB:    return row[2*DIN_WIDTH +: DIN_WIDTH];
      W_ABRE:  return row[1*DIN_WIDTH +: DIN_WIDTH];
      default: return row[0 +: DIN_WIDTH];
    endcase
  endfunction

  // A full FIFO still accepts a frame when the head frame finishes this cycle.
  assign w_push   = din_valid && (!w_full || w_pop);
  assign w_drop   = din_valid && w_full && !w_pop;
  assign w_wr_row = {r_seq, aa, bb, ab_re, ab_im};

  corr_frame_fifo #(
    .ROW_W (ROW_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst),
    .i_push     (w_push),
    .i_pop      (w_pop),
    .i_wr_row   (w_wr_row),
    .o_head_row (w_head_row),
    .o_next_row (w_next_row),
    .o_level    (w_level),
    .o_full     (w_full),
    .o_empty    (w_empty)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_seq      <= '0;
      r_drop_cnt <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (din_valid) r_seq <= r_seq + DIN_WIDTH'(1);
      if (clear_stats) begin
        r_drop_cnt <= '0;
        r_overflow <= 1'b0;
      end else if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_drop_cnt != '1) r_drop_cnt <= r_drop_cnt + DROP_CNT_WIDTH'(1);
      end
    end
  end

  assign w_idx_inc = r_idx + 3'd1;

  // Read FSM: next word is preloaded into the output register on each handshake.
  always_comb begin
    w_state_nxt  = r_state;
    w_idx_nxt    = r_idx;
    w_tdata_nxt  = r_tdata;
    w_tvalid_nxt = r_tvalid;
    w_tlast_nxt  = r_tlast;
    w_pop        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_state_nxt  = ST_SEND;
          w_idx_nxt    = FIRST_IDX;
          w_tdata_nxt  = sel_word(w_head_row, FIRST_IDX);
          w_tvalid_nxt = 1'b1;
          w_tlast_nxt  = 1'b0;
        end
      end
      ST_SEND: begin
        if (m_axis_tready) begin
          if (r_idx == W_ABIM) begin
            w_pop = 1'b1;
            if (w_level > LVL_W'(1)) begin
              w_idx_nxt   = FIRST_IDX;
              w_tdata_nxt = sel_word(w_next_row, FIRST_IDX);
              w_tlast_nxt = 1'b0;
            end else begin
              w_state_nxt  = ST_IDLE;
              w_tvalid_nxt = 1'b0;
              w_tlast_nxt  = 1'b0;
            end
          end else begin
            w_idx_nxt   = w_idx_inc;
            w_tdata_nxt = sel_word(w_head_row, w_idx_inc);
            w_tlast_nxt = (w_idx_inc == W_ABIM);
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= ST_IDLE;
      r_idx    <= '0;
      r_tdata  <= '0;
      r_tvalid <= 1'b0;
      r_tlast  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_idx    <= w_idx_nxt;
      r_tdata  <= w_tdata_nxt;
      r_tvalid <= w_tvalid_nxt;
      r_tlast  <= w_tlast_nxt;
    end
  end

  assign m_axis_tdata  = r_tdata;
  assign m_axis_tvalid = r_tvalid;
  assign m_axis_tlast  = r_tlast;
  assign fifo_level    = w_level;
  assign drop_count    = r_drop_cnt;
  assign overflow      = r_overflow;

endmodule

// File: tb/tb_corr_frame_packer.sv
// Directed bench for corr_frame_packer with a word scoreboard on the header-enabled instance.
module tb_corr_frame_packer;

  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned LW    = 4;
  localparam int unsigned DCW   = 16;

  typedef struct packed {
    logic          last;
    logic [DW-1:0] data;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] aa, bb, ab_re, ab_im;
  logic          din_valid, tready, clear_stats;
  logic [DW-1:0] tdata;
  logic          tvalid, tlast, ovf;
  logic [LW-1:0] level;
  logic [DCW-1:0] drops;

  logic           din_valid0, tready0, clear0;
  logic [DW-1:0]  tdata0;
  logic           tvalid0, tlast0, ovf0;
  logic [LW-1:0]  level0;
  logic [DCW-1:0] drops0;

  int checks = 0;
  int errors = 0;

  exp_t          q[$];
  int            m_level;
  logic [DW-1:0] m_seq;
  logic [DCW-1:0] m_drops;
  logic          m_ovf;
  bit            stalled, exp_valid;
  logic [DW-1:0] s_data;
  logic          s_last;

  always #5 clk = ~clk;

  corr_frame_packer #(.DIN_WIDTH(DW), .FIFO_DEPTH(DEPTH), .INCLUDE_HEADER(1), .DROP_CNT_WIDTH(DCW)) dut (
    .clk(clk), .rst(rst), .aa(aa), .bb(bb), .ab_re(ab_re), .ab_im(ab_im),
    .din_valid(din_valid), .m_axis_tdata(tdata), .m_axis_tvalid(tvalid),
    .m_axis_tready(tready), .m_axis_tlast(tlast), .fifo_level(level),
    .drop_count(drops), .overflow(ovf), .clear_stats(clear_stats)
  );

  corr_frame_packer #(.DIN_WIDTH(DW), .FIFO_DEPTH(DEPTH), .INCLUDE_HEADER(0), .DROP_CNT_WIDTH(DCW)) dut0 (
    .clk(clk), .rst(rst), .aa(aa), .bb(bb), .ab_re(ab_re), .ab_im(ab_im),
    .din_valid(din_valid0), .m_axis_tdata(tdata0), .m_axis_tvalid(tvalid0),
    .m_axis_tready(tready0), .m_axis_tlast(tlast0), .fifo_level(level0),
    .drop_count(drops0), .overflow(ovf0), .clear_stats(clear0)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: check stream at negedge, update model, return at posedge+1.
  task automatic tick();
    exp_t e;
    bit   hs_last;
    @(negedge clk);
    hs_last = 1'b0;
    if (exp_valid) begin
      chk("no_gap_tvalid", 64'(tvalid), 64'd1);
      exp_valid = 1'b0;
    end
    if (stalled) begin
      chk("hold_tvalid", 64'(tvalid), 64'd1);
      chk("hold_tdata", 64'(tdata), 64'(s_data));
      chk("hold_tlast", 64'(tlast), 64'(s_last));
    end
    if (tvalid && tready) begin
      if (q.size() == 0) begin
        chk("spurious_word", 64'(q.size()), 64'd1);
      end else begin
        e = q.pop_front();
        chk("tdata", 64'(tdata), 64'(e.data));
        chk("tlast", 64'(tlast), 64'(e.last));
        hs_last = e.last;
        if (e.last && q.size() != 0) exp_valid = 1'b1;
      end
    end
    stalled = tvalid && !tready;
    s_data  = tdata;
    s_last  = tlast;
    if (din_valid) begin
      if (m_level < int'(DEPTH) || hs_last) begin
        q.push_back({1'b0, m_seq});
        q.push_back({1'b0, aa});
        q.push_back({1'b0, bb});
        q.push_back({1'b0, ab_re});
        q.push_back({1'b1, ab_im});
        m_level++;
      end else begin
        m_ovf = 1'b1;
        if (m_drops != '1) m_drops++;
      end
      m_seq++;
    end
    if (hs_last) m_level--;
    if (clear_stats) begin
      m_drops = '0;
      m_ovf   = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    din_valid = 1'b0; din_valid0 = 1'b0;
    clear_stats = 1'b0; clear0 = 1'b0;
    #1;
    chk("rst_tvalid", 64'(tvalid), 64'd0);
    chk("rst_tlast", 64'(tlast), 64'd0);
    chk("rst_tdata", 64'(tdata), 64'd0);
    chk("rst_level", 64'(level), 64'd0);
    chk("rst_drops", 64'(drops), 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);
    chk("rst_tvalid0", 64'(tvalid0), 64'd0);
    q.delete();
    m_level = 0; m_seq = '0; m_drops = '0; m_ovf = 1'b0;
    stalled = 1'b0; exp_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [DW-1:0] a, input logic [DW-1:0] b,
                      input logic [DW-1:0] re, input logic [DW-1:0] im);
    aa = a; bb = b; ab_re = re; ab_im = im;
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
  endtask

  task automatic drain(input bit toggle);
    for (int k = 0; k < 300 && (q.size() != 0 || tvalid); k++) begin
      if (toggle) tready = ~tready;
      tick();
    end
    chk("drain_queue_empty", 64'(q.size()), 64'd0);
    chk("drain_tvalid_low", 64'(tvalid), 64'd0);
  endtask

  task automatic send0();
    din_valid0 = 1'b1;
    tick();
    din_valid0 = 1'b0;
  endtask

  initial begin
    logic [DW-1:0] w0 [4];
    rst = 1'b1; din_valid = 1'b0; tready = 1'b0; clear_stats = 1'b0;
    din_valid0 = 1'b0; tready0 = 1'b0; clear0 = 1'b0;
    aa = '0; bb = '0; ab_re = '0; ab_im = '0;
    @(posedge clk);
    #1;
    do_reset();

    // Single frame: latency and content.
    tready = 1'b1;
    send(32'h10, 32'h20, 32'hFFFF_FFFD, 32'h5);
    chk("lat_n1_tvalid", 64'(tvalid), 64'd0);
    tick();
    chk("lat_n2_tvalid", 64'(tvalid), 64'd1);
    chk("lat_n2_hdr", 64'(tdata), 64'd0);
    chk("lat_level", 64'(level), 64'd1);
    drain(1'b0);
    chk("single_level_after", 64'(level), 64'd0);

    // Back-pressure: tready toggles every cycle over three frames.
    do_reset();
    tready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      send(32'h100 + 32'(i), 32'h200 + 32'(i), 32'h300 + 32'(i), 32'h400 + 32'(i));
      tready = ~tready;
    end
    drain(1'b1);

    // Overflow: ten frames into a stalled stream.
    do_reset();
    tready = 1'b0;
    for (int i = 0; i < 10; i++)
      send(32'hA00 + 32'(i), 32'hB00 + 32'(i), 32'hC00 + 32'(i), 32'hD00 + 32'(i));
    tick();
    chk("ovf_level", 64'(level), 64'd8);
    chk("ovf_level_model", 64'(level), 64'(m_level));
    chk("ovf_drops", 64'(drops), 64'd2);
    chk("ovf_drops_model", 64'(drops), 64'(m_drops));
    chk("ovf_flag", 64'(ovf), 64'd1);

    // Full plus pop: new frame lands on the last-word handshake.
    tready = 1'b1;
    for (int k = 0; k < 20 && !tlast; k++) tick();
    chk("fp_tlast_reached", 64'(tlast), 64'd1);
    send(32'hE0, 32'hE1, 32'hE2, 32'hE3);
    chk("fp_drops", 64'(drops), 64'd2);
    chk("fp_level", 64'(level), 64'd8);
    chk("fp_ovf", 64'(ovf), 64'd1);
    drain(1'b0);

    // Reset mid-frame with three frames queued.
    do_reset();
    tready = 1'b0;
    for (int i = 0; i < 3; i++)
      send(32'h50 + 32'(i), 32'h60, 32'h70, 32'h80);
    tick();
    tready = 1'b1;
    tick();
    tick();
    do_reset();
    tready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("post_rst_idle", 64'(tvalid), 64'd0);
    end
    send(32'h91, 32'h92, 32'h93, 32'h94);
    tick();
    chk("post_rst_hdr", 64'(tdata), 64'd0);
    drain(1'b0);

    // Header-less instance: 4-word frames, clear_stats beats a drop.
    do_reset();
    tready0 = 1'b0;
    aa = 32'hA1; bb = 32'hB2; ab_re = 32'hFFFF_FFFF; ab_im = 32'h7;
    w0[0] = 32'hA1; w0[1] = 32'hB2; w0[2] = 32'hFFFF_FFFF; w0[3] = 32'h7;
    send0();
    tick();
    tick();
    chk("nh_level", 64'(level0), 64'd1);
    tready0 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("nh_tvalid", 64'(tvalid0), 64'd1);
      chk("nh_tdata", 64'(tdata0), 64'(w0[i]));
      chk("nh_tlast", 64'(tlast0), (i == 3) ? 64'd1 : 64'd0);
      tick();
    end
    chk("nh_done", 64'(tvalid0), 64'd0);
    tready0 = 1'b0;
    for (int i = 0; i < 8; i++) send0();
    chk("nh_full_level", 64'(level0), 64'd8);
    clear0 = 1'b1;
    send0();
    clear0 = 1'b0;
    chk("clr_drop_count", 64'(drops0), 64'd0);
    chk("clr_overflow", 64'(ovf0), 64'd0);
    send0();
    chk("nh_drop_count", 64'(drops0), 64'd1);
    chk("nh_overflow", 64'(ovf0), 64'd1);
    chk("nh_level_held", 64'(level0), 64'd8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
